// File: rtl/esp_ide_pkg.sv
// Shared definitions for the ESP32 disk co-processor slave: frame commands, status bits, frame states.
// Latency: none (declarations only).
// Backpressure: none.
package esp_ide_pkg;

    localparam logic [7:0] CMD_GET  = 8'h01;
    localparam logic [7:0] CMD_PUT  = 8'h02;
    localparam logic [7:0] CMD_BOUT = 8'h03;
    localparam logic [7:0] CMD_BIN  = 8'h04;

    // Bit positions inside the r7 status byte seen by the CPU
    localparam int BSY = 7;
    localparam int DRQ = 3;

    localparam int NUM_REGS = 7;

    typedef enum logic [2:0] {
        IDLE,
        GET,
        PUT,
        BOUT,
        BIN
    } state_e;

endpackage

// File: rtl/esp_spi_byte.sv
// SPI mode-0 byte engine: input synchroniser, sclk edge detect, MSB-first shift in/out.
// Latency: byte_done/rx_byte registered one clk after the 8th synchronised rising edge.
// Backpressure: none; tx_byte must be loaded (tx_load) before the following falling edge.
module esp_spi_byte #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       spi_miso,
    output logic       csn_s,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    // Each stage holds {csn, sclk, mosi}
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] sync_d [SYNC_STAGES];
    logic       sclk_s, mosi_s, sclk_prev_q, rise, fall;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, rx_byte_q, rx_byte_d;
    logic       miso_q, miso_d, done_q, done_d;

    // Synchroniser chain input shift
    always_comb begin
        sync_d[0] = {spi_csn, spi_sclk, spi_mosi};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign csn_s  = sync_q[SYNC_STAGES-1][2];
    assign sclk_s = sync_q[SYNC_STAGES-1][1];
    assign mosi_s = sync_q[SYNC_STAGES-1][0];
    assign rise   = ~csn_s & sclk_s & ~sclk_prev_q;
    assign fall   = ~csn_s & ~sclk_s & sclk_prev_q;

    // Shift engine: sample on rise, present next bit on fall, deselect clears framing
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_sh_d   = rx_sh_q;
        tx_sh_d   = tx_sh_q;
        miso_d    = miso_q;
        rx_byte_d = rx_byte_q;
        done_d    = 1'b0;
        if (csn_s) begin
            bit_cnt_d = 3'd0;
            tx_sh_d   = 8'h00;
            miso_d    = 1'b0;
        end else begin
            if (rise) begin
                rx_sh_d   = {rx_sh_q[6:0], mosi_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    done_d    = 1'b1;
                    rx_byte_d = {rx_sh_q[6:0], mosi_s};
                end
            end
            if (fall) begin
                miso_d  = tx_sh_q[7];
                tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
            // Load lands between the 8th rise and the next fall, so it never meets a shift
            if (tx_load) begin
                tx_sh_d = tx_byte;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 3'b100;
            end
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_sh_q     <= 8'h00;
            tx_sh_q     <= 8'h00;
            rx_byte_q   <= 8'h00;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            sclk_prev_q <= sclk_s;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_byte_q   <= rx_byte_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
        end
    end

    assign spi_miso  = miso_q;
    assign byte_done = done_q;
    assign rx_byte   = rx_byte_q;

endmodule

// File: rtl/esp_ide_slave.sv
// IDE task-file + sector buffer shared between the CPU bus and the ESP32 SPI frame protocol.
// Latency: host_rdata one clk after host_sel; SPI out-byte loaded one clk after each byte completes.
// Backpressure: none; CPU and SPI sides always accepted, buffer is dual-ported.
module esp_ide_slave
    import esp_ide_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BUF_BYTES   = 512
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       irq,
    input  logic       host_sel,
    input  logic       host_we,
    input  logic [2:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata
);

    localparam int PW = $clog2(BUF_BYTES);
    localparam int CW = PW + 1;

    logic          csn_s, byte_done, load_q;
    logic [7:0]    rx_byte, tx_byte;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] sptr_q, sptr_d, hptr_q, hptr_d;
    logic [2:0]    seq_idx;
    logic          spi_we, put_we, put_done, host_mem_we, host_rd_en, irq_q, irq_d;
    logic          src_mem_q, src_mem_d;
    logic [7:0]    reg_rdata_q, reg_rdata_d, status, ram_host_q, ram_spi_q;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];
    logic [7:0]    mem [BUF_BYTES];

    esp_spi_byte #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
        .clk       (clk),
        .rstn      (rstn),
        .spi_csn   (spi_csn),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .tx_load   (load_q),
        .tx_byte   (tx_byte),
        .spi_miso  (spi_miso),
        .csn_s     (csn_s),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    // r1..r7 map to index 0..6; cnt runs 7..1 through GET/PUT frames
    assign seq_idx = 3'd7 - cnt_q[2:0];
    assign status  = {irq_q, regs_q[6][6:0]};

    // Frame FSM: command decode, byte counting, SPI-side buffer pointer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sptr_d   = sptr_q;
        spi_we   = 1'b0;
        put_we   = 1'b0;
        put_done = 1'b0;
        if (csn_s) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (byte_done) begin
            case (state_q)
                IDLE: begin
                    case (rx_byte)
                        CMD_GET:  begin state_d = GET;  cnt_d = CW'(7); end
                        CMD_PUT:  begin state_d = PUT;  cnt_d = CW'(7); end
                        CMD_BOUT: begin state_d = BOUT; cnt_d = CW'(BUF_BYTES); sptr_d = '0; end
                        CMD_BIN:  begin state_d = BIN;  cnt_d = CW'(BUF_BYTES); sptr_d = '0; end
                        default:  state_d = IDLE;
                    endcase
                end
                GET: cnt_d = cnt_q - CW'(1);
                PUT: begin
                    put_we   = 1'b1;
                    put_done = (cnt_q == CW'(1));
                    cnt_d    = cnt_q - CW'(1);
                end
                BOUT: begin
                    sptr_d = sptr_q + PW'(1);
                    cnt_d  = cnt_q - CW'(1);
                end
                BIN: begin
                    spi_we = 1'b1;
                    sptr_d = sptr_q + PW'(1);
                    cnt_d  = cnt_q - CW'(1);
                end
                default: state_d = IDLE;
            endcase
            if (state_q != IDLE && cnt_q == CW'(1)) begin
                state_d = IDLE;
            end
        end
    end

    // Task file, irq and CPU read path; CPU updates are applied after SPI ones so they win
    always_comb begin
        regs_d      = regs_q;
        irq_d       = irq_q;
        hptr_d      = hptr_q;
        reg_rdata_d = reg_rdata_q;
        src_mem_d   = src_mem_q;
        host_mem_we = 1'b0;
        host_rd_en  = 1'b0;
        if (put_we) begin
            regs_d[seq_idx] = rx_byte;
        end
        if (put_done) begin
            irq_d  = 1'b0;
            hptr_d = '0;
        end
        if (host_sel) begin
            if (host_addr == 3'd0) begin
                host_mem_we = host_we;
                host_rd_en  = ~host_we;
                if (!host_we) begin
                    src_mem_d = 1'b1;
                end
                if (hptr_q == PW'(BUF_BYTES - 1)) begin
                    hptr_d = '0;
                    // Wrap during a data phase ends the sector transfer
                    if (regs_q[6][DRQ]) begin
                        irq_d = 1'b1;
                    end
                end else begin
                    hptr_d = hptr_q + PW'(1);
                end
            end else if (host_we) begin
                regs_d[host_addr - 3'd1] = host_wdata;
                if (host_addr == 3'd7) begin
                    irq_d = 1'b1;
                end
            end else begin
                src_mem_d   = 1'b0;
                reg_rdata_d = (host_addr == 3'd7) ? status : regs_q[host_addr - 3'd1];
            end
        end
    end

    // Next SPI out-byte, evaluated the cycle after the FSM has advanced
    always_comb begin
        case (state_q)
            GET:     tx_byte = regs_q[seq_idx];
            BOUT:    tx_byte = ram_spi_q;
            default: tx_byte = 8'h00;
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sptr_q      <= '0;
            hptr_q      <= '0;
            irq_q       <= 1'b0;
            load_q      <= 1'b0;
            src_mem_q   <= 1'b0;
            reg_rdata_q <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sptr_q      <= sptr_d;
            hptr_q      <= hptr_d;
            irq_q       <= irq_d;
            load_q      <= byte_done;
            src_mem_q   <= src_mem_d;
            reg_rdata_q <= reg_rdata_d;
            regs_q      <= regs_d;
        end
    end

    // Dual-port sector buffer; reads see the pre-write contents
    always_ff @(posedge clk) begin
        if (host_mem_we) begin
            mem[hptr_q] <= host_wdata;
        end
        if (spi_we) begin
            mem[sptr_q] <= rx_byte;
        end
        if (host_rd_en) begin
            ram_host_q <= mem[hptr_q];
        end
        ram_spi_q <= mem[sptr_d];
    end

    assign irq        = irq_q;
    assign host_rdata = src_mem_q ? ram_host_q : reg_rdata_q;

endmodule

// File: tb/tb_esp_ide_slave.sv
// Directed bench for esp_ide_slave: CPU register table, SPI GET/PUT/BOUT/BIN frames, corner sequences.
// Latency: inputs driven on clk falling edges, outputs sampled on falling edges.
// Backpressure: not applicable.
module tb_esp_ide_slave;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       host_sel = 1'b0;
    logic       host_we = 1'b0;
    logic [2:0] host_addr = 3'd0;
    logic [7:0] host_wdata = 8'h00;
    logic       spi_miso, irq;
    logic [7:0] host_rdata;

    int         n_checks = 0;
    int         n_fail = 0;
    int         bad;
    logic [7:0] d, rx;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } hvec_t;
    hvec_t tab [8];

    esp_ide_slave dut (
        .clk        (clk),
        .rstn       (rstn),
        .spi_csn    (spi_csn),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .irq        (irq),
        .host_sel   (host_sel),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata)
    );

    always #20 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [7:0] v);
        @(negedge clk);
        host_sel = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = v;
        @(negedge clk);
        host_sel = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_rd(input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        host_sel = 1'b1; host_we = 1'b0; host_addr = a;
        @(negedge clk);
        host_sel = 1'b0;
        v = host_rdata;
    endtask

    // One SPI byte, 3 clk per half period; optional CPU r7 write aligned with byte completion
    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] r,
                            input logic inj, input logic [7:0] inj_val);
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (3) @(negedge clk);
            r[i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (3) @(negedge clk);
            spi_sclk = 1'b0;
            if (inj && i == 0) begin
                host_sel = 1'b1; host_we = 1'b1; host_addr = 3'd7; host_wdata = inj_val;
                @(negedge clk);
                host_sel = 1'b0; host_we = 1'b0;
            end
        end
    endtask

    task automatic xf(input logic [7:0] tx, output logic [7:0] r);
        spi_xfer(tx, r, 1'b0, 8'h00);
    endtask

    task automatic csn_lo();
        @(negedge clk);
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic csn_hi();
        @(negedge clk);
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Full GET frame; exp holds r1 in the top byte down to r7 in the bottom byte
    task automatic get_check(input string tag, input logic [55:0] exp);
        logic [7:0]  r;
        logic [55:0] got;
        got = '0;
        xf(8'h01, r);
        check({tag, "_cmd"}, r, 8'h00);
        for (int k = 0; k < 7; k++) begin
            xf(8'h00, r);
            got = {got[47:0], r};
        end
        check(tag, got, exp);
    endtask

    task automatic put_frame(input logic [55:0] vals, input logic inj, input logic [7:0] inj_val);
        logic [7:0] r;
        xf(8'h02, r);
        for (int k = 0; k < 7; k++) begin
            spi_xfer(vals[55 - 8*k -: 8], r, inj && (k == 6), inj_val);
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_irq", irq, 1'b0);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_rdata", host_rdata, 8'h00);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: CPU register table, then GET
        tab[0] = '{1'b1, 3'd3, 8'h34, 8'h00};
        tab[1] = '{1'b1, 3'd4, 8'h12, 8'h00};
        tab[2] = '{1'b1, 3'd7, 8'h20, 8'h00};
        tab[3] = '{1'b0, 3'd3, 8'h00, 8'h34};
        tab[4] = '{1'b0, 3'd1, 8'h00, 8'h00};
        tab[5] = '{1'b0, 3'd7, 8'h00, 8'hA0};
        tab[6] = '{1'b0, 3'd6, 8'h00, 8'h00};
        tab[7] = '{1'b0, 3'd4, 8'h00, 8'h12};
        for (int i = 0; i < 8; i++) begin
            if (tab[i].we) begin
                host_wr(tab[i].addr, tab[i].wdata);
                if (tab[i].addr == 3'd7) check("irq_after_cmd", irq, 1'b1);
            end else begin
                host_rd(tab[i].addr, d);
                check($sformatf("tab%0d_r%0d", i, tab[i].addr), d, tab[i].exp);
            end
        end
        repeat (3) @(negedge clk);
        check("rdata_hold", host_rdata, 8'h12);
        csn_lo();
        get_check("get1", 56'h00_00_34_12_00_00_20);
        csn_hi();

        // 2: BIN sector, PUT DRQ, CPU reads the sector
        csn_lo();
        xf(8'h04, rx);
        for (int i = 0; i < 512; i++) xf(8'(i), rx);
        csn_hi();
        csn_lo();
        put_frame(56'h00_00_00_00_00_00_08, 1'b0, 8'h00);
        csn_hi();
        check("put_irq_clr", irq, 1'b0);
        host_rd(3'd7, d);
        check("status_drq", d, 8'h08);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (i == 511) check("irq_before_last_rd", irq, 1'b0);
            host_rd(3'd0, d);
            if (d !== 8'(i)) bad++;
        end
        check("buf_rd_errors", bad, 0);
        check("irq_after_rd_wrap", irq, 1'b1);
        csn_lo();
        put_frame(56'h0, 1'b0, 8'h00);
        csn_hi();
        check("put0_irq_clr", irq, 1'b0);

        // 3: CPU writes sector, BOUT reads it back
        host_wr(3'd7, 8'h30);
        check("irq_cmd30", irq, 1'b1);
        csn_lo();
        put_frame(56'h00_00_00_00_00_00_08, 1'b0, 8'h00);
        csn_hi();
        check("put_irq_clr2", irq, 1'b0);
        for (int i = 0; i < 512; i++) begin
            if (i == 511) check("irq_before_last_wr", irq, 1'b0);
            host_wr(3'd0, 8'hA5);
        end
        check("irq_after_wr_wrap", irq, 1'b1);
        csn_lo();
        xf(8'h03, rx);
        check("bout_cmd_byte", rx, 8'h00);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            xf(8'h00, rx);
            if (rx !== 8'hA5) bad++;
        end
        check("bout_errors", bad, 0);
        csn_hi();

        // 4: csn abort mid-GET, unknown command
        for (int i = 1; i <= 6; i++) host_wr(3'(i), 8'(i * 8'h11));
        csn_lo();
        xf(8'h01, rx);
        xf(8'h00, rx);
        check("partial_get_r1", rx, 8'h11);
        xf(8'h00, rx);
        csn_hi();
        csn_lo();
        get_check("get_after_abort", 56'h11_22_33_44_55_66_08);
        xf(8'h7E, rx);
        check("unknown_cmd_out", rx, 8'h00);
        get_check("get_after_unknown", 56'h11_22_33_44_55_66_08);
        csn_hi();

        // 5: CPU r7 write in the same cycle the PUT frame completes
        csn_lo();
        put_frame(56'hA1_A2_A3_A4_A5_A6_08, 1'b1, 8'h55);
        csn_hi();
        check("collide_irq", irq, 1'b1);
        host_rd(3'd7, d);
        check("collide_status", d, 8'hD5);
        host_rd(3'd1, d);
        check("collide_r1", d, 8'hA1);
        host_rd(3'd6, d);
        check("collide_r6", d, 8'hA6);

        // 6: reset during a BIN transfer
        csn_lo();
        xf(8'h04, rx);
        for (int i = 0; i < 100; i++) xf(8'hC3, rx);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_irq", irq, 1'b0);
        check("midrst_miso", spi_miso, 1'b0);
        check("midrst_rdata", host_rdata, 8'h00);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        get_check("get_after_rst", 56'h0);
        host_wr(3'd2, 8'h9C);
        get_check("get_after_rst2", 56'h00_9C_00_00_00_00_00);
        host_rd(3'd7, d);
        check("status_after_rst", d, 8'h00);
        csn_hi();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
